// File: rtl/dummy.sv
// dummy: STAGES-deep register pipeline from d to q with a fill flag.
// Optional per-bit edge flags on q when DUMMY_EDGE_DET_EN is defined.
//
// Parameters:
//   WIDTH     - data width of d, q, rise, fall
//   STAGES    - pipeline depth, 1..16
//   RESET_VAL - value loaded into every stage while rstn is low
// Ports:
//   clk    in   rising-edge clock
//   rstn   in   asynchronous active-low reset
//   d      in   data input, sampled every rising edge
//   q      out  last pipeline stage (flop output)
//   filled out  high once STAGES samples have entered since reset
//   rise   out  per-bit q rising-edge flag (DUMMY_EDGE_DET_EN only)
//   fall   out  per-bit q falling-edge flag (DUMMY_EDGE_DET_EN only)
module dummy #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             filled
`ifdef DUMMY_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int             CW   = $clog2(STAGES + 1);
    localparam logic [CW-1:0]  FULL = CW'(STAGES);

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [CW-1:0]    r_cnt;
    logic             r_filled;
    logic [CW-1:0]    w_cnt_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

    // Saturating fill counter; filled is registered from the
    // next count so it lines up with the sample reaching q.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_cnt != FULL) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_filled <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_filled <= (w_cnt_nxt == FULL);
        end
    end

    assign filled = r_filled;

`ifdef DUMMY_EDGE_DET_EN
    // Value q will take on the coming edge; comparing it with the
    // current q (which becomes "previous") lets the flags be flops.
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    if (STAGES == 1) begin : g_nxt_d
        assign w_q_nxt = d;
    end else begin : g_nxt_stage
        assign w_q_nxt = r_stage[STAGES-2];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_q_nxt & ~q;
            r_fall <= ~w_q_nxt & q;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule

// File: tb/tb_dummy.sv
// tb_dummy: scoreboard bench for dummy (three parameterisations).
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
`timescale 1ns/100ps
module tb_dummy;

    typedef enum int {
        S_Q0, S_F0, S_RISE, S_FALL,
        S_Q1, S_F1, S_Q2, S_F2
    } sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn0, rstn1, rstn2;
    logic       d0;
    logic [7:0] d1, d2;
    logic       q0, f0, f1, f2;
    logic [7:0] q1, q2;
    logic       rise0, fall0;
    logic [7:0] rise1, fall1, rise2, fall2;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dummy u0 (
        .clk    (clk),
        .rstn   (rstn0),
        .d      (d0),
        .q      (q0),
        .filled (f0)
`ifdef DUMMY_EDGE_DET_EN
        ,
        .rise   (rise0),
        .fall   (fall0)
`endif
    );

    dummy #(.WIDTH(8), .STAGES(4)) u1 (
        .clk    (clk),
        .rstn   (rstn1),
        .d      (d1),
        .q      (q1),
        .filled (f1)
`ifdef DUMMY_EDGE_DET_EN
        ,
        .rise   (rise1),
        .fall   (fall1)
`endif
    );

    dummy #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5)) u2 (
        .clk    (clk),
        .rstn   (rstn2),
        .d      (d2),
        .q      (q2),
        .filled (f2)
`ifdef DUMMY_EDGE_DET_EN
        ,
        .rise   (rise2),
        .fall   (fall2)
`endif
    );

`ifndef DUMMY_EDGE_DET_EN
    assign rise0 = 1'b0;
    assign fall0 = 1'b0;
    assign rise1 = '0;
    assign fall1 = '0;
    assign rise2 = '0;
    assign fall2 = '0;
`endif

    function automatic logic [7:0] actual(sig_e s);
        case (s)
            S_Q0:    return {7'b0, q0};
            S_F0:    return {7'b0, f0};
            S_RISE:  return {7'b0, rise0};
            S_FALL:  return {7'b0, fall0};
            S_Q1:    return q1;
            S_F1:    return {7'b0, f1};
            S_Q2:    return q2;
            default: return {7'b0, f2};
        endcase
    endfunction

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic push(int c, sig_e s, logic [7:0] v, string nm);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Monitor: at each falling edge, retire every expectation due now.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s stale cyc=%0d now=%0d",
                         sb[i].nm, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                check($sformatf("%s@%0d", sb[i].nm, cyc),
                      actual(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic edges(int c, logic r, logic f);
`ifdef DUMMY_EDGE_DET_EN
        push(c, S_RISE, {7'b0, r}, "rise0");
        push(c, S_FALL, {7'b0, f}, "fall0");
`else
        if (r === 1'bx || f === 1'bx) push(c, S_Q0, 8'hxx, "edge_arg");
`endif
    endtask

    // STAGES=1, WIDTH=1: reset hold, latency, edge flags.
    task automatic run_u0();
        rstn0 = 1'b0;
        d0    = 1'b1;
        push(1, S_Q0, 8'h0, "hold_q0");
        push(1, S_F0, 8'h0, "hold_f0");
        push(2, S_Q0, 8'h0, "hold_q0");
        push(2, S_F0, 8'h0, "hold_f0");
        #16 d0 = 1'b0;
        #1  rstn0 = 1'b1;
        push(3, S_Q0, 8'h0, "lat_q0");
        push(3, S_F0, 8'h1, "fill_f0");
        edges(3, 1'b0, 1'b0);
        #10 d0 = 1'b1;
        push(4, S_Q0, 8'h1, "lat_q0");
        push(4, S_F0, 8'h1, "fill_f0");
        edges(4, 1'b1, 1'b0);
        #10 d0 = 1'b0;
        push(5, S_Q0, 8'h0, "lat_q0");
        edges(5, 1'b0, 1'b1);
        #10 d0 = 1'b1;
        push(6, S_Q0, 8'h1, "lat_q0");
        edges(6, 1'b1, 1'b0);
        #10 d0 = 1'b1;
        push(7, S_Q0, 8'h1, "lat_q0");
        edges(7, 1'b0, 1'b0);
        #10 d0 = 1'b0;
        push(8, S_Q0, 8'h0, "lat_q0");
        edges(8, 1'b0, 1'b1);
        #10 d0 = 1'b0;
        push(9, S_Q0, 8'h0, "lat_q0");
        push(9, S_F0, 8'h1, "fill_f0");
        edges(9, 1'b0, 1'b0);
    endtask

    // STAGES=4, WIDTH=8: depth and saturating fill.
    task automatic run_u1();
        rstn1 = 1'b0;
        d1    = 8'h00;
        push(1, S_Q1, 8'h00, "rst_q1");
        push(1, S_F1, 8'h00, "rst_f1");
        push(2, S_Q1, 8'h00, "rst_q1");
        push(2, S_F1, 8'h00, "rst_f1");
        #17 rstn1 = 1'b1;
        #5  d1 = 8'h01;
        for (int n = 1; n <= 54; n++) begin
            push(n + 2, S_Q1, (n >= 4) ? 8'(n - 3) : 8'h00, "depth_q1");
            push(n + 2, S_F1, (n >= 4) ? 8'h01 : 8'h00, "fill_f1");
            @(posedge clk);
            #2 d1 = d1 + 8'h01;
        end
    endtask

    // STAGES=2, RESET_VAL=A5: async reset in mid-operation.
    task automatic run_u2();
        rstn2 = 1'b0;
        d2    = 8'h3C;
        push(1, S_Q2, 8'hA5, "rst_q2");
        push(1, S_F2, 8'h00, "rst_f2");
        push(2, S_Q2, 8'hA5, "rst_q2");
        #17 rstn2 = 1'b1;
        push(3, S_Q2, 8'hA5, "run_q2");
        push(3, S_F2, 8'h00, "run_f2");
        push(4, S_Q2, 8'h3C, "run_q2");
        push(4, S_F2, 8'h01, "run_f2");
        #25 rstn2 = 1'b0;
        #1;
        check("async_q2", q2, 8'hA5);
        check("async_f2", {7'b0, f2}, 8'h00);
        push(5, S_Q2, 8'hA5, "rsthold_q2");
        push(5, S_F2, 8'h00, "rsthold_f2");
    endtask

    initial begin
        fork
            run_u0();
            run_u1();
            run_u2();
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dummy.md
DUMMY -- requirements
Module: dummy

Interface
REQ-001 The parameter WIDTH SHALL default to 1 and set the data width of d and q.
REQ-002 The parameter STAGES SHALL default to 1 (legal 1..16) and set the register-stage count from d to q.
REQ-003 The parameter RESET_VAL SHALL default to all-zeros (WIDTH bits) and set the value loaded into every stage by reset.
REQ-004 clk  input  1  The sole clock; all state SHALL update on its rising edge only.
REQ-005 rstn  input  1  The reset, asynchronous and active-low.
REQ-006 d  input  WIDTH  Data input, sampled on each rising clk edge.
REQ-007 q  output  WIDTH  Data output, the last pipeline stage, driven directly from a flop.
REQ-008 filled  output  1  High once STAGES valid samples have entered since reset release.
REQ-009 rise  output  WIDTH  Per-bit rising-edge flag (DUMMY_EDGE_DET_EN only).
REQ-010 fall  output  WIDTH  Per-bit falling-edge flag (DUMMY_EDGE_DET_EN only).

Function
REQ-011 The block SHALL be a STAGES-deep shift pipeline: stage 0 takes d, and stage k takes stage k-1 on every rising clk edge with rstn high.
REQ-012 q SHALL equal the d value sampled STAGES rising edges earlier; with default STAGES=1, q follows d with a latency of exactly one rising edge.
REQ-013 The pipeline SHALL have no enable or stall; every rising edge with rstn high shifts it.
REQ-014 filled SHALL be driven by a saturating counter of 0..STAGES that increments on each rising edge with rstn high, and filled SHALL be 1 when the count equals STAGES.
REQ-015 The counter SHALL saturate at STAGES and SHALL NOT wrap around.
REQ-016 All outputs SHALL be glitch-free registered values; there SHALL be no combinational path from d to any output.
REQ-017 The block SHALL NOT synchronise d; d SHALL be synchronous to clk and stable around each rising edge.

Reset
REQ-018 While rstn is low, every stage SHALL hold RESET_VAL, q SHALL be RESET_VAL, filled SHALL be 0, and rise and fall SHALL be 0.
REQ-019 Assertion of rstn SHALL take effect immediately, with no clock required, including in the middle of operation; all in-flight data SHALL be discarded.
REQ-020 The first rising edge with rstn high SHALL capture d into stage 0.
REQ-021 When rstn is released in the same time step as a rising edge, the block SHALL either capture d on that edge or defer capture to the next edge, and no output SHALL leave its reset value on that edge.
REQ-022 Benches SHALL release rstn away from rising clk edges.

Configuration
REQ-023 With DUMMY_EDGE_DET_EN defined, the rise and fall ports and their logic SHALL exist, and after each rising edge rise[i] SHALL equal (q[i] new AND NOT q[i] previous) and fall[i] SHALL equal (NOT q[i] new AND q[i] previous).
REQ-024 With DUMMY_EDGE_DET_EN defined, the previous-q register SHALL reset to RESET_VAL, so that no edge is flagged on the first edge after reset unless q changes.
REQ-025 Without DUMMY_EDGE_DET_EN, the rise and fall ports SHALL be absent and no logic SHALL be generated for them.
REQ-026 All other behaviour SHALL be identical with and without DUMMY_EDGE_DET_EN.

Verification
REQ-027 Reset hold: with 10 ns clock, rstn=0 and d=1 for 15 ns -> q=0 and filled=0 throughout.
REQ-028 Latency with STAGES=1: release rstn at 17 ns, set d=1 at 27 ns, d=0 at 37 ns, d=1 at 47 ns -> q=1 after the 35 ns edge, q=0 after the 45 ns edge, q=1 after the 55 ns edge; filled=1 after the 25 ns edge.
REQ-029 Depth with STAGES=4 and WIDTH=8: drive d=0x01,0x02,0x03,... on successive edges -> q shows 0x01 exactly 4 edges after it was sampled; filled rises on the 4th edge after release and stays 1 for 50 further edges.
REQ-030 Mid-operation reset: pull rstn low at 42 ns while the pipeline is full -> q=RESET_VAL and filled=0 at 42 ns without waiting for a clock edge.
REQ-031 Edge detect (DUMMY_EDGE_DET_EN, STAGES=1): d sequence 0,1,1,0 -> rise pulses high for one cycle after q goes 0 to 1, fall pulses high for one cycle after q goes 1 to 0, and both are otherwise 0.
